seq_signed_multiplier: RTL
==========================

SEQ_SIGNED_MULTIPLIER -- requirements
Module: seq_signed_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-low.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only when idle.
REQ-005 Port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: a  input  WIDTH  multiplicand; sampled with start.
REQ-007 Port: b  input  WIDTH  multiplier; sampled with start.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; p is valid.
REQ-010 Port: p  output  2*WIDTH  registered product.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, FIX.
REQ-012 IDLE with start=1 at an edge SHALL latch a, b and signed_mode, then enter CALC with busy=1 and iteration count 0.
REQ-013 Latching SHALL capture operand magnitudes: in signed mode, negative operands are two's-complement negated; in unsigned mode, operands are taken as-is, zero-extended. The result sign is a[MSB] XOR b[MSB] in signed mode and 0 otherwise.
REQ-014 CALC SHALL perform exactly WIDTH shift-add iterations, one per edge, in a 2*WIDTH-bit accumulator: add the shifted multiplicand when the current multiplier bit is 1, then shift the multiplicand left by 1.
REQ-015 After the WIDTH-th iteration, CALC SHALL enter FIX.
REQ-016 FIX SHALL, in one edge:
- write p = accumulator, negated mod 2^(2*WIDTH) if the result sign is 1;
- set done=1 and busy=0;
- enter IDLE.
REQ-017 Latency: done SHALL be high in the cycle following the (WIDTH+1)-th rising edge after the edge that accepted start (9 edges for WIDTH=8).
REQ-018 done SHALL be high for exactly one cycle per completed multiply.
REQ-019 p SHALL change only at the FIX edge and SHALL otherwise hold its value indefinitely.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 Changes on a, b or signed_mode after acceptance SHALL NOT affect the result.
REQ-022 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-023 Most-negative operand (e.g. 0x80 for WIDTH=8) SHALL have magnitude 2^(WIDTH-1) in signed mode and produce the exact product; no overflow is possible in 2*WIDTH bits.
REQ-024 A zero operand with result sign 1 SHALL yield p=0.

Reset
REQ-025 rst=0 at a rising edge SHALL force state IDLE, busy=0, done=0, p=0, accumulator and iteration count 0.
REQ-026 Reset SHALL dominate start in the same cycle.
REQ-027 Reset mid-operation SHALL abort the multiply; no done pulse SHALL follow for the aborted operation.
REQ-028 After reset releases, the first start SHALL be accepted normally.

Verification
REQ-029 Signed, WIDTH=8:
- a=0x82, b=0x86 -> p=0x3C0C, done 9 cycles after start;
- a=0x06, b=0x56 -> p=0x0204.
REQ-030 WIDTH=8, a=0xFF, b=0xFF:
- unsigned -> p=0xFE01;
- signed -> p=0x0001.
REQ-031 Signed, WIDTH=8:
- a=0x80, b=0x80 -> p=0x4000;
- a=0x80, b=0x7F -> p=0xC080;
- a=0x00, b=0x80 -> p=0x0000.
REQ-032 Reset mid-operation: start a multiply, drive rst=0 for one edge at the 4th CALC edge -> next cycle busy=0, done=0, p=0; no done pulse for 20 cycles; a new start then completes correctly.
REQ-033 Handshake:
- start pulsed while busy -> ignored, p unchanged;
- start held high on the done cycle -> second result after exactly WIDTH+1 further edges;
- operand changes during CALC -> no effect on p.
REQ-034 WIDTH=16 instance, signed: a=0x8000, b=0xFFFF -> p=0x00008000; done 17 edges after start.

Source files
------------

// File: rtl/seq_signed_multiplier_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The requester drives master; the multiplier consumes slave.
interface seq_signed_multiplier_if #(
  parameter int WIDTH = 8
) ();
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_signed_multiplier.sv
// Shift-add sequential multiplier, signed or unsigned per request.
// Multiplies operand magnitudes over WIDTH cycles, then applies the result sign.
module seq_signed_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_signed_multiplier_if.slave bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    p_r;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             done_r;

  // Most-negative input negates to itself, which read unsigned is 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    logic signed [WIDTH-1:0] sv;
    sv = $signed(v);
    return (sgn && sv < 0) ? $unsigned(-sv) : v;
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                               input logic s);
    return s ? -v : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand  <= '0;
      acc    <= '0;
      p_r    <= '0;
      mplier <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= PW'(magnitude(bus.a, bus.signed_mode));
            mplier <= magnitude(bus.b, bus.signed_mode);
            neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        FIX: begin
          p_r    <= apply_sign(acc, neg);
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule
